// File: rtl/secded2_128_errlog_pkg.sv
// Shared constants, log-type encodings and FSM states for the SECDED error logger.
package secded2_pkg;

    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        LOG_NONE  = 2'b00,
        LOG_CORR  = 2'b01,
        LOG_FATAL = 2'b10
    } log_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOGGED = 2'b01,
        S_FATAL  = 2'b10
    } state_e;

    // Detected-but-not-corrected counts as fatal even without the fatal flag.
    function automatic log_type_e classify(input logic valid, input logic corr,
                                           input logic detec, input logic fatal);
        if (!valid) begin
            return LOG_NONE;
        end else if (fatal || (detec && !corr)) begin
            return LOG_FATAL;
        end else if (detec && corr) begin
            return LOG_CORR;
        end else begin
            return LOG_NONE;
        end
    endfunction

endpackage

// File: rtl/secded2_sat_cnt.sv
// Saturating event counter; a clear coincident with an increment loads one.
module secded2_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Counter state: clear/load-one has priority, otherwise count up to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= inc ? W'(1'b1) : '0;
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/secded2_128_errlog.sv
// SECDED decoder output register with error classification, counters and a one-entry log.
// Optional data poisoning of fatal beats is enabled by defining SECDED2_ERRLOG_POISON_EN.
module secded2_128_errlog
    import secded2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    input  logic [0:DATA_W-1] i_data,
    input  logic              i_err_corr,
    input  logic              i_err_detec,
    input  logic              i_err_fatal,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CNT_W-1:0]  i_thresh,
    input  logic              i_ack,
    input  logic              i_clr,
    output logic [0:DATA_W-1] o_data,
    output logic              o_valid,
    output logic              o_poison,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_fatal_cnt,
    output logic [ADDR_W-1:0] o_log_addr,
    output logic [1:0]        o_log_type,
    output logic              o_overflow,
    output logic              o_thresh_hit,
    output logic              o_irq
);

    log_type_e         beat_s;
    logic              corr_beat_s;
    logic              fatal_beat_s;
    logic [CNT_W-1:0]  corr_cnt_s;
    logic [CNT_W-1:0]  fatal_cnt_s;
    state_e            state_r;
    log_type_e         log_type_r;
    logic [ADDR_W-1:0] log_addr_r;
    logic              overflow_r;
    logic [0:DATA_W-1] data_r;
    logic              valid_r;

    assign beat_s       = classify(i_valid, i_err_corr, i_err_detec, i_err_fatal);
    assign corr_beat_s  = (beat_s == LOG_CORR);
    assign fatal_beat_s = (beat_s == LOG_FATAL);

    secded2_sat_cnt #(.W(CNT_W)) u_corr_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (i_clr),
        .inc   (corr_beat_s),
        .cnt   (corr_cnt_s)
    );

    secded2_sat_cnt #(.W(CNT_W)) u_fatal_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (i_clr),
        .inc   (fatal_beat_s),
        .cnt   (fatal_cnt_s)
    );

`ifdef SECDED2_ERRLOG_POISON_EN
    logic poison_r;

    // Output register: fatal beats are replaced by an all-ones poisoned word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r   <= '0;
            valid_r  <= 1'b0;
            poison_r <= 1'b0;
        end else if (fatal_beat_s) begin
            data_r   <= {DATA_W{1'b1}};
            valid_r  <= i_valid;
            poison_r <= 1'b1;
        end else begin
            data_r   <= i_data;
            valid_r  <= i_valid;
            poison_r <= 1'b0;
        end
    end

    assign o_poison = poison_r;
`else
    // Output register: data passes through unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            data_r  <= i_data;
            valid_r <= i_valid;
        end
    end

    assign o_poison = 1'b0;
`endif

    // Log FSM: clear wins and then treats the coincident beat as arriving in idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            log_type_r <= LOG_NONE;
            log_addr_r <= '0;
            overflow_r <= 1'b0;
        end else if (i_clr) begin
            overflow_r <= 1'b0;
            case (beat_s)
                LOG_CORR: begin
                    state_r    <= S_LOGGED;
                    log_type_r <= LOG_CORR;
                    log_addr_r <= i_addr;
                end
                LOG_FATAL: begin
                    state_r    <= S_FATAL;
                    log_type_r <= LOG_FATAL;
                    log_addr_r <= i_addr;
                end
                default: begin
                    state_r    <= S_IDLE;
                    log_type_r <= LOG_NONE;
                    log_addr_r <= '0;
                end
            endcase
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (corr_beat_s) begin
                        state_r    <= S_LOGGED;
                        log_type_r <= LOG_CORR;
                        log_addr_r <= i_addr;
                    end else if (fatal_beat_s) begin
                        state_r    <= S_FATAL;
                        log_type_r <= LOG_FATAL;
                        log_addr_r <= i_addr;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOGGED: begin
                    if (fatal_beat_s) begin
                        state_r    <= S_FATAL;
                        log_type_r <= LOG_FATAL;
                        log_addr_r <= i_addr;
                        overflow_r <= 1'b1;
                    end else if (corr_beat_s && i_ack) begin
                        // Ack frees the slot in the same edge, so the new event is not lost.
                        log_type_r <= LOG_CORR;
                        log_addr_r <= i_addr;
                    end else if (corr_beat_s) begin
                        overflow_r <= 1'b1;
                    end else if (i_ack) begin
                        state_r    <= S_IDLE;
                        log_type_r <= LOG_NONE;
                    end else begin
                        state_r <= S_LOGGED;
                    end
                end
                S_FATAL: begin
                    if (beat_s != LOG_NONE) begin
                        overflow_r <= 1'b1;
                    end else begin
                        overflow_r <= overflow_r;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    log_type_r <= LOG_NONE;
                    log_addr_r <= '0;
                end
            endcase
        end
    end

    assign o_data       = data_r;
    assign o_valid      = valid_r;
    assign o_corr_cnt   = corr_cnt_s;
    assign o_fatal_cnt  = fatal_cnt_s;
    assign o_log_addr   = log_addr_r;
    assign o_log_type   = log_type_r;
    assign o_overflow   = overflow_r;
    assign o_thresh_hit = (i_thresh != '0) && (corr_cnt_s >= i_thresh);
    assign o_irq        = (state_r == S_FATAL) || ((state_r == S_LOGGED) && o_thresh_hit);

endmodule

// File: tb/tb_secded2_128_errlog.sv
// Table-driven scoreboard bench for secded2_128_errlog, built with 4-bit counters.
module tb_secded2_128_errlog;

    localparam int AW = 32;
    localparam int CW = 4;

    typedef struct {
        logic v, cor, det, fat, ack, clr;
        logic [AW-1:0]  addr;
        logic [127:0]   data;
        logic [CW-1:0]  thr;
        logic [CW-1:0]  e_cc, e_fc;
        logic [1:0]     e_lt;
        logic [AW-1:0]  e_la;
        logic           e_ovf, e_irq, e_th;
        logic           e_valid, e_poison;
        logic [127:0]   e_data;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           i_valid, i_err_corr, i_err_detec, i_err_fatal, i_ack, i_clr;
    logic [0:127]   i_data;
    logic [AW-1:0]  i_addr;
    logic [CW-1:0]  i_thresh;
    logic [0:127]   o_data;
    logic           o_valid, o_poison, o_overflow, o_thresh_hit, o_irq;
    logic [CW-1:0]  o_corr_cnt, o_fatal_cnt;
    logic [AW-1:0]  o_log_addr;
    logic [1:0]     o_log_type;

    int checks = 0;
    int failures = 0;
    vec_t exp_q[$];
    vec_t tbl[17];

    secded2_128_errlog #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
        .i_err_corr(i_err_corr), .i_err_detec(i_err_detec), .i_err_fatal(i_err_fatal),
        .i_addr(i_addr), .i_thresh(i_thresh), .i_ack(i_ack), .i_clr(i_clr),
        .o_data(o_data), .o_valid(o_valid), .o_poison(o_poison),
        .o_corr_cnt(o_corr_cnt), .o_fatal_cnt(o_fatal_cnt), .o_log_addr(o_log_addr),
        .o_log_type(o_log_type), .o_overflow(o_overflow), .o_thresh_hit(o_thresh_hit),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, cor, det, fat, ack, clr,
                                input logic [AW-1:0] addr, input logic [127:0] data,
                                input logic [CW-1:0] thr, input logic [CW-1:0] cc, fc,
                                input logic [1:0] lt, input logic [AW-1:0] la,
                                input logic ovf, irq, th);
        vec_t t;
        t.v = v; t.cor = cor; t.det = det; t.fat = fat; t.ack = ack; t.clr = clr;
        t.addr = addr; t.data = data; t.thr = thr;
        t.e_cc = cc; t.e_fc = fc; t.e_lt = lt; t.e_la = la;
        t.e_ovf = ovf; t.e_irq = irq; t.e_th = th;
        t.e_valid = 1'b0; t.e_poison = 1'b0; t.e_data = 128'h0;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_valid = 1'b0; i_err_corr = 1'b0; i_err_detec = 1'b0; i_err_fatal = 1'b0;
        i_ack = 1'b0; i_clr = 1'b0; i_addr = '0; i_data = '0; i_thresh = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 128'(o_valid), 128'h0);
        chk({tag, "_data"}, 128'(o_data), 128'h0);
        chk({tag, "_poison"}, 128'(o_poison), 128'h0);
        chk({tag, "_ccnt"}, 128'(o_corr_cnt), 128'h0);
        chk({tag, "_fcnt"}, 128'(o_fatal_cnt), 128'h0);
        chk({tag, "_ltype"}, 128'(o_log_type), 128'h0);
        chk({tag, "_laddr"}, 128'(o_log_addr), 128'h0);
        chk({tag, "_ovf"}, 128'(o_overflow), 128'h0);
        chk({tag, "_irq"}, 128'(o_irq), 128'h0);
    endtask

    // Drive one beat, queue its expectation, then pop and compare after the edge.
    task automatic step(input vec_t t, input string tag);
        vec_t g;
        t.e_valid = t.v; t.e_data = t.data; t.e_poison = 1'b0;
`ifdef SECDED2_ERRLOG_POISON_EN
        if (t.v && (t.fat || (t.det && !t.cor))) begin
            t.e_data = {128{1'b1}};
            t.e_poison = 1'b1;
        end
`endif
        i_valid = t.v; i_err_corr = t.cor; i_err_detec = t.det; i_err_fatal = t.fat;
        i_ack = t.ack; i_clr = t.clr; i_addr = t.addr; i_data = t.data; i_thresh = t.thr;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk({tag, "_valid"}, 128'(o_valid), 128'(g.e_valid));
        chk({tag, "_data"}, 128'(o_data), g.e_data);
        chk({tag, "_poison"}, 128'(o_poison), 128'(g.e_poison));
        chk({tag, "_ccnt"}, 128'(o_corr_cnt), 128'(g.e_cc));
        chk({tag, "_fcnt"}, 128'(o_fatal_cnt), 128'(g.e_fc));
        chk({tag, "_ltype"}, 128'(o_log_type), 128'(g.e_lt));
        chk({tag, "_laddr"}, 128'(o_log_addr), 128'(g.e_la));
        chk({tag, "_ovf"}, 128'(o_overflow), 128'(g.e_ovf));
        chk({tag, "_irq"}, 128'(o_irq), 128'(g.e_irq));
        chk({tag, "_thit"}, 128'(o_thresh_hit), 128'(g.e_th));
    endtask

    initial begin
        //               v    cor  det  fat  ack  clr  addr    data          thr   cc   fc   lt     la      ovf  irq  th
        tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  128'h1234,   4'd2, 4'd0,4'd0,2'b00,32'h0,  1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h40, 128'hAAAA,   4'd2, 4'd1,4'd0,2'b01,32'h40, 1'b0,1'b0,1'b0);
        tbl[2]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h44, 128'h5555,   4'd2, 4'd2,4'd0,2'b01,32'h40, 1'b1,1'b1,1'b1);
        tbl[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  128'h0,      4'd2, 4'd2,4'd0,2'b00,32'h40, 1'b1,1'b0,1'b1);
        tbl[4]  = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'h80, 128'h0,      4'd2, 4'd2,4'd1,2'b10,32'h80, 1'b1,1'b1,1'b1);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  128'h0,      4'd2, 4'd2,4'd1,2'b10,32'h80, 1'b1,1'b1,1'b1);
        tbl[6]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h84, 128'h77,     4'd2, 4'd3,4'd1,2'b10,32'h80, 1'b1,1'b1,1'b1);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,  128'h0,      4'd2, 4'd0,4'd0,2'b00,32'h0,  1'b0,1'b0,1'b0);
        tbl[8]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'hC0, 128'h9,      4'd2, 4'd1,4'd0,2'b01,32'hC0, 1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,32'hC4, 128'hA,      4'd2, 4'd2,4'd0,2'b01,32'hC4, 1'b0,1'b1,1'b1);
        tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  128'h0,      4'd2, 4'd2,4'd0,2'b00,32'hC4, 1'b0,1'b0,1'b1);
        tbl[11] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'hD0, 128'hBEEF,   4'd2, 4'd2,4'd1,2'b10,32'hD0, 1'b0,1'b1,1'b1);
        tbl[12] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,32'hE0, 128'hCAFE,   4'd2, 4'd0,4'd1,2'b10,32'hE0, 1'b0,1'b1,1'b0);
        tbl[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,  128'h0,      4'd2, 4'd0,4'd0,2'b00,32'h0,  1'b0,1'b0,1'b0);
        tbl[14] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'hF0, 128'hF00D,   4'd2, 4'd0,4'd0,2'b00,32'h0,  1'b0,1'b0,1'b0);
        tbl[15] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h100,128'h1,      4'd0, 4'd1,4'd0,2'b01,32'h100,1'b0,1'b0,1'b0);
        tbl[16] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'h104,128'h2,      4'd0, 4'd1,4'd1,2'b10,32'h104,1'b1,1'b1,1'b0);

        drive_idle();
        reset_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_reset");

        for (int i = 0; i < 17; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturation: clear, then 17 corrected beats into a 4-bit counter.
        step(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,128'h0,4'd0,
                4'd0,4'd0,2'b00,32'h0,1'b0,1'b0,1'b0), "sat_clr");
        for (int i = 0; i < 17; i++) begin
            step(mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h200,128'(i),4'd0,
                    (i >= 14) ? 4'hF : 4'(i + 1), 4'd0, 2'b01, 32'h200,
                    (i > 0) ? 1'b1 : 1'b0, 1'b0, 1'b0), $sformatf("sat%0d", i));
        end

        // Reset mid-operation drops the in-flight beat and the log.
        @(negedge clk);
        i_valid = 1'b1; i_err_detec = 1'b1; i_err_fatal = 1'b1; i_addr = 32'h300;
        i_data = 128'hDEAD;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("rst_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
